adc_pattern_tx: RTL
===================

# adc_pattern_tx

Synthesizable transmitter that drives an 11-bit single-data-rate ADC-style bus: 10 sample bits, a DOR over-range bit and a data clock. Its outputs are exactly what `sdr_rx_11_100` expects on a channel (`{DOR, D9..D0}` plus `DCLK`). It is used for on-board loopback self-test of the sample capture path (bus receiver → data bus FIFO → entry_maker) without the ADC fitted. It generates constant, ramp, pulse and pseudo-random patterns, paced from `system_clock`.

## Interface
Parameters:
- `DIV`, default 2: half-period of `dclk` in `system_clock` cycles; legal range 1..255.
- `SEED`, default 10'h001: LFSR reset value; must be nonzero.

Ports (one clock; reset is asynchronous and active-low):
- `system_clock` in 1: sole clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `enable` in 1: run the generator; low forces the idle outputs.
- `mode` in 2: 0 CONST, 1 RAMP, 2 PULSE, 3 PRBS.
- `level` in 10: constant value, and the baseline in PULSE mode.
- `pulse_amp` in 10: pulse height added to `level`.
- `pulse_width` in 8: pulse length in samples; 0 is treated as 1.
- `period` in 16: samples between automatic pulse starts; 0 disables automatic starts.
- `start_pulse` in 1: single-cycle request for one pulse.
- `busy` out 1: pulse in progress.
- `dclk` out 1: bus data clock.
- `dout` out 10: sample bits (D9 is the MSB).
- `dor` out 1: over-range indicator.
- `sample_count` out 16: number of samples emitted; wraps.

## Operation
- Reset: `dclk`=0, `dout`=0, `dor`=0, `busy`=0, `sample_count`=0, ramp counter=0, LFSR=`SEED`, pulse FSM in IDLE, divider counter=0.
- `enable` low (synchronous):
  - Same outputs and divider as reset.
  - Ramp counter, LFSR and `sample_count` hold their values.
  - Pulse FSM returns to IDLE.
- Sample tick: the cycle in which the divider commands `dclk` 1→0. On each tick, `dout`/`dor` load the next sample and `sample_count` increments.
- Pattern per sample:
  - CONST: `dout`=`level`, `dor`=0.
  - RAMP: `dout`=ramp counter, then the counter increments; 1023 wraps to 0; `dor`=1 only on the 1023 sample.
  - PULSE: sum = `level` + (`pulse_amp` if ACTIVE, else 0), computed at 11 bits.
    - If sum > 1023: `dout`=1023, `dor`=1 (saturate).
    - Otherwise: `dout`=sum, `dor`=0.
  - PRBS: `dout`=LFSR, `dor`=0; then the LFSR advances with polynomial x^10+x^7+1, shifting toward the MSB (the feedback bit is [9]^[6] and enters at [0]).
- Pattern generators advance only on ticks where their mode is selected.
- `mode`, `level` and `pulse_amp` are sampled at each tick; a change takes effect on the next sample.
- Pulse FSM, evaluated at ticks:
  - IDLE→ACTIVE on a pending start, i.e. `start_pulse` latched since the last tick, or the period counter reaching `period`-1.
  - ACTIVE for max(`pulse_width`,1) samples, then → IDLE.
  - `busy` = state ACTIVE.
  - A start while ACTIVE is discarded (the latch clears).
  - The period counter counts samples in PULSE mode, resets to 0 on each automatic start, and holds at 0 when `period`=0.
  - `start_pulse` while `enable` is low is ignored.
  - The FSM only leaves IDLE in PULSE mode; leaving PULSE mode mid-pulse returns it to IDLE at the next tick.

## Timing
- On the first cycle `enable` is sampled high, `dout`/`dor` load sample 0 and `sample_count` becomes 1.
- `dclk` then rises `DIV` cycles later and falls `DIV` cycles after that (a tick). Period = 2·`DIV` system clocks.
- Data changes only on `dclk` falling edges. Data is therefore stable for `DIV` cycles either side of each rising edge, which is where the receiver captures.
- Latency: `start_pulse` → first pulse sample at the next tick, ≤ 2·`DIV` cycles.
- `RESETN` asserted mid-sample forces outputs low asynchronously. After release, operation restarts as if `enable` had just risen (if `enable` is high).
- `sample_count` wraps from 65535 to 0 without a flag.

## Structure
- Shared package `adc_tx_pkg`: mode encodings (MODE_CONST, MODE_RAMP, MODE_PULSE, MODE_PRBS), `SAMPLE_MAX`=10'd1023, LFSR tap constants.
- One sub-module is natural: `adc_tx_lfsr` (10-bit, step enable, seed parameter).
- Divider, ramp counter, pulse FSM and output registers stay in the top module.

## Test plan
- `DIV`=2, CONST, `level`=10'h155, `enable` rising → `dclk` period 4 cycles; `dout`=10'h155 stable at every rising edge; `dor`=0.
- RAMP from reset, 1025 samples → `dout` 0..1023 then 0; `dor`=1 only on the 1023 sample; `sample_count`=1025.
- PULSE, `level`=100, `pulse_amp`=50, `pulse_width`=3, `start_pulse` once → samples 100, 150, 150, 150, 100; `busy` high for 3 ticks. A second `start_pulse` mid-pulse produces no extra pulse.
- PULSE, `level`=1000, `pulse_amp`=100, `period`=8, `pulse_width`=0 → every 8th sample is 1023 with `dor`=1, all other samples are 1000; the pulse is 1 sample long.
- PRBS, `SEED`=1 → first samples 10'h001, 10'h002, 10'h004; sequence repeats after exactly 1023 samples and never emits 0.
- `RESETN` pulsed low mid-pulse and mid-`dclk`-high → `dclk`/`dout`/`dor`/`busy` go to 0 at once; after release, sample 0 reloads on the first enabled cycle.

Source files
------------

// File: rtl/adc_tx_pkg.sv
// Shared definitions for the ADC-style pattern transmitter: mode encodings,
// sample range and the LFSR polynomial x^10 + x^7 + 1.
package adc_tx_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_PULSE = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_e;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

    localparam logic [9:0] SAMPLE_MAX = 10'd1023;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // Shift toward the MSB; feedback enters at bit 0.
    function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
        return {cur[8:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/adc_tx_lfsr.sv
// 10-bit Fibonacci LFSR with step enable; holds its value when not stepped.
module adc_tx_lfsr
    import adc_tx_pkg::*;
#(
    parameter logic [9:0] SEED = 10'h001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [9:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/adc_pattern_tx.sv
// Single-data-rate ADC bus transmitter ({dor, dout} plus dclk) producing
// constant, ramp, pulse and PRBS samples for capture-path loopback.
module adc_pattern_tx
    import adc_tx_pkg::*;
#(
    parameter int         DIV  = 2,
    parameter logic [9:0] SEED = 10'h001
) (
    input  logic        system_clock,
    input  logic        RESETN,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [9:0]  level,
    input  logic [9:0]  pulse_amp,
    input  logic [7:0]  pulse_width,
    input  logic [15:0] period,
    input  logic        start_pulse,
    output logic        busy,
    output logic        dclk,
    output logic [9:0]  dout,
    output logic        dor,
    output logic [15:0] sample_count
);

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    mode_e        cur_mode;
    pulse_state_e state, state_next;
    logic         run;
    logic [7:0]   div_cnt;
    logic         tick;
    logic [9:0]   ramp_cnt;
    logic [9:0]   lfsr_q;
    logic [7:0]   pcnt, pcnt_next;
    logic [15:0]  per_cnt;
    logic         start_latch;
    logic         pulse_mode, auto_start, start_req, pulse_on;
    logic [7:0]   w_eff;
    logic [10:0]  sum;
    logic [9:0]   samp;
    logic         samp_dor;

    assign cur_mode = mode_e'(mode);
    assign busy     = (state == PULSE_ACTIVE);

    // The first enabled cycle is itself a tick; afterwards ticks are dclk falls.
    assign tick = enable && (!run || (dclk && div_cnt == DIV_M1));

    adc_tx_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (system_clock),
        .rst_n (RESETN),
        .step  (tick && cur_mode == MODE_PRBS),
        .q     (lfsr_q)
    );

    always_comb begin
        pulse_mode = (cur_mode == MODE_PULSE);
        w_eff      = (pulse_width == 8'd0) ? 8'd1 : pulse_width;
        auto_start = pulse_mode && (period != 16'd0) && (per_cnt >= period - 16'd1);
        start_req  = start_latch || start_pulse || auto_start;
        state_next = state;
        pcnt_next  = pcnt;
        pulse_on   = 1'b0;
        case (state)
            PULSE_IDLE: begin
                if (pulse_mode && start_req) begin
                    state_next = PULSE_ACTIVE;
                    pcnt_next  = 8'd1;
                    pulse_on   = 1'b1;
                end
            end
            PULSE_ACTIVE: begin
                if (!pulse_mode || pcnt >= w_eff) begin
                    state_next = PULSE_IDLE;
                end else begin
                    pulse_on  = 1'b1;
                    pcnt_next = pcnt + 8'd1;
                end
            end
            default: state_next = PULSE_IDLE;
        endcase
    end

    always_comb begin
        sum      = {1'b0, level} + (pulse_on ? {1'b0, pulse_amp} : 11'd0);
        samp     = '0;
        samp_dor = 1'b0;
        case (cur_mode)
            MODE_CONST: samp = level;
            MODE_RAMP: begin
                samp     = ramp_cnt;
                samp_dor = (ramp_cnt == SAMPLE_MAX);
            end
            MODE_PULSE: begin
                if (sum > {1'b0, SAMPLE_MAX}) begin
                    samp     = SAMPLE_MAX;
                    samp_dor = 1'b1;
                end else begin
                    samp = sum[9:0];
                end
            end
            MODE_PRBS: samp = lfsr_q;
            default: samp = '0;
        endcase
    end

    // Pulse FSM state register; it only moves on ticks.
    always_ff @(posedge system_clock or negedge RESETN) begin
        if (!RESETN) begin
            state <= PULSE_IDLE;
            pcnt  <= '0;
        end else if (!enable) begin
            state <= PULSE_IDLE;
            pcnt  <= '0;
        end else if (tick) begin
            state <= state_next;
            pcnt  <= pcnt_next;
        end
    end

    always_ff @(posedge system_clock or negedge RESETN) begin
        if (!RESETN) begin
            run          <= 1'b0;
            div_cnt      <= '0;
            dclk         <= 1'b0;
            dout         <= '0;
            dor          <= 1'b0;
            sample_count <= '0;
            ramp_cnt     <= '0;
            per_cnt      <= '0;
            start_latch  <= 1'b0;
        end else if (!enable) begin
            run         <= 1'b0;
            div_cnt     <= '0;
            dclk        <= 1'b0;
            dout        <= '0;
            dor         <= 1'b0;
            per_cnt     <= '0;
            start_latch <= 1'b0;
        end else begin
            run <= 1'b1;
            if (!run) begin
                div_cnt <= '0;
            end else if (div_cnt == DIV_M1) begin
                div_cnt <= '0;
                dclk    <= ~dclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (tick) begin
                dout         <= samp;
                dor          <= samp_dor;
                sample_count <= sample_count + 16'd1;
                start_latch  <= 1'b0;
                if (cur_mode == MODE_RAMP) ramp_cnt <= ramp_cnt + 10'd1;
                if (pulse_mode) begin
                    if (auto_start || period == 16'd0) per_cnt <= '0;
                    else                               per_cnt <= per_cnt + 16'd1;
                end
            end else if (start_pulse) begin
                start_latch <= 1'b1;
            end
        end
    end

endmodule
